// File: rtl/seeded_lfsr_rng.sv
// Memory-seeded Galois LFSR random generator: fetches a seed word, then streams
// LFSR states through a valid/ready handshake (or free-runs), with run-time reseeding.
module seeded_lfsr_rng #(
  parameter int                 WIDTH        = 16,
  parameter int                 OUT_BITS     = 4,
  parameter int                 ADDR_W       = 16,
  parameter logic [WIDTH-1:0]   TAPS         = 16'hB400,
  parameter logic [ADDR_W-1:0]  SEED_ADDR    = '0,
  parameter logic [WIDTH-1:0]   SEED_DEFAULT = 16'hACE1,
  parameter int                 MEM_LAT      = 1,
  parameter bit                 FREE_RUN     = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd_en,
  input  logic [WIDTH-1:0]    mem_data_out,
  input  logic                reseed,
  input  logic                rng_ready,
  output logic                rng_valid,
  output logic [WIDTH-1:0]    rng_out,
  output logic [OUT_BITS-1:0] rng_out_small,
  output logic                mux_select
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t             r_fsm;
  logic [WIDTH-1:0]   r_state;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_rd_en;
  logic               r_valid;
  logic               r_mux;

  logic               w_advance;
  logic [WIDTH-1:0]   w_next_state;

  assign w_advance    = (r_fsm == S_RUN) && (FREE_RUN || (r_valid && rng_ready));
  assign w_next_state = r_state[0] ? ((r_state >> 1) ^ TAPS) : (r_state >> 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fsm     <= S_FETCH;
      r_state   <= '0;
      r_lat_cnt <= '0;
      r_addr    <= SEED_ADDR;
      r_rd_en   <= 1'b0;
      r_valid   <= 1'b0;
      r_mux     <= 1'b1;
    end else begin
      case (r_fsm)
        S_FETCH: begin
          // The read is issued on the first FETCH cycle after reset; a reseed issues it directly.
          if (!r_rd_en) begin
            r_rd_en <= 1'b1;
          end else if (r_lat_cnt == LAT_LAST) begin
            r_fsm     <= S_LOAD;
            r_rd_en   <= 1'b0;
            r_lat_cnt <= '0;
          end else begin
            r_lat_cnt <= r_lat_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= (mem_data_out == '0) ? SEED_DEFAULT : mem_data_out;
          r_fsm   <= S_RUN;
          r_valid <= 1'b1;
          r_mux   <= 1'b0;
        end
        S_RUN: begin
          if (w_advance) begin
            r_state <= w_next_state;
          end
          if (reseed) begin
            r_fsm     <= S_FETCH;
            r_valid   <= 1'b0;
            r_mux     <= 1'b1;
            r_addr    <= r_addr + 1'b1;
            r_rd_en   <= 1'b1;
            r_lat_cnt <= '0;
          end
        end
        default: begin
          r_fsm <= S_FETCH;
        end
      endcase
    end
  end

  assign mem_addr      = r_addr;
  assign mem_rd_en     = r_rd_en;
  assign rng_valid     = r_valid;
  assign rng_out       = r_state;
  assign rng_out_small = r_state[OUT_BITS-1:0];
  assign mux_select    = r_mux;

endmodule
